// File: rtl/cache_mem_arbiter.sv
// Shares one memory read channel (round-robin icache/dcache, one outstanding read)
// and one serialized dcache write channel, stalling same-line reads behind a pending write.
module cache_mem_arbiter #(
  parameter int unsigned WR_DATA_W     = 128,
  parameter int unsigned LINE_OFF_BITS = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_rd_req,
  input  logic [2:0]           i_rd_type,
  input  logic [31:0]          i_rd_addr,
  output logic                 i_rd_rdy,
  output logic                 i_ret_valid,
  output logic                 i_ret_last,
  output logic [31:0]          i_ret_data,
  input  logic                 d_rd_req,
  input  logic [2:0]           d_rd_type,
  input  logic [31:0]          d_rd_addr,
  output logic                 d_rd_rdy,
  output logic                 d_ret_valid,
  output logic                 d_ret_last,
  output logic [31:0]          d_ret_data,
  input  logic                 d_wr_req,
  input  logic [2:0]           d_wr_type,
  input  logic [31:0]          d_wr_addr,
  input  logic [3:0]           d_wr_wstrb,
  input  logic [WR_DATA_W-1:0] d_wr_data,
  output logic                 d_wr_rdy,
  output logic                 m_rd_req,
  output logic [2:0]           m_rd_type,
  output logic [31:0]          m_rd_addr,
  input  logic                 m_rd_rdy,
  input  logic                 m_ret_valid,
  input  logic                 m_ret_last,
  input  logic [31:0]          m_ret_data,
  output logic                 m_wr_req,
  output logic [2:0]           m_wr_type,
  output logic [31:0]          m_wr_addr,
  output logic [3:0]           m_wr_wstrb,
  output logic [WR_DATA_W-1:0] m_wr_data,
  input  logic                 m_wr_rdy,
  input  logic                 m_wr_done
);

  localparam int unsigned LINE_W = 32 - LINE_OFF_BITS;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  // last_grant / owner: 1 = dcache, 0 = icache
  logic              last_grant;
  logic              owner;
  logic              wr_accept;
  logic              grant_i;
  logic              grant_d;
  logic              i_elig;
  logic              d_elig;
  logic              hazard_on;
  logic [LINE_W-1:0] hazard_line;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Request fields captured on acceptance; they drive the memory side until the next accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      m_rd_type  <= 3'd0;
      m_rd_addr  <= 32'd0;
      m_wr_type  <= 3'd0;
      m_wr_addr  <= 32'd0;
      m_wr_wstrb <= 4'd0;
      m_wr_data  <= WR_DATA_W'(0);
    end else begin
      if (grant_i || grant_d) begin
        owner      <= grant_d;
        last_grant <= grant_d;
        m_rd_type  <= grant_d ? d_rd_type : i_rd_type;
        m_rd_addr  <= grant_d ? d_rd_addr : i_rd_addr;
      end
      if (wr_accept) begin
        m_wr_type  <= d_wr_type;
        m_wr_addr  <= d_wr_addr;
        m_wr_wstrb <= d_wr_wstrb;
        m_wr_data  <= d_wr_data;
      end
    end
  end

  always_comb begin
    r_next      = r_state;
    w_next      = w_state;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    d_wr_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    i_ret_data  = 32'd0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    d_ret_data  = 32'd0;
    m_rd_req    = 1'b0;
    m_wr_req    = 1'b0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    d_wr_rdy  = resetn && (w_state == W_IDLE);
    wr_accept = d_wr_rdy && d_wr_req;

    // A write being accepted this cycle already blocks reads of its line
    hazard_on   = (w_state != W_IDLE) || wr_accept;
    hazard_line = (w_state != W_IDLE) ? m_wr_addr[31:LINE_OFF_BITS]
                                      : d_wr_addr[31:LINE_OFF_BITS];
    i_elig = i_rd_req && !(hazard_on && (i_rd_addr[31:LINE_OFF_BITS] == hazard_line));
    d_elig = d_rd_req && !(hazard_on && (d_rd_addr[31:LINE_OFF_BITS] == hazard_line));

    case (w_state)
      W_IDLE: if (wr_accept) w_next = W_REQ;
      W_REQ: begin
        m_wr_req = 1'b1;
        if (m_wr_rdy) w_next = W_RESP;
      end
      W_RESP: if (m_wr_done) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase

    case (r_state)
      R_IDLE: begin
        if (resetn) begin
          grant_i = i_elig && (!d_elig || last_grant);
          grant_d = d_elig && (!i_elig || !last_grant);
        end
        i_rd_rdy = grant_i;
        d_rd_rdy = grant_d;
        if (grant_i || grant_d) r_next = R_REQ;
      end
      R_REQ: begin
        m_rd_req = 1'b1;
        if (m_rd_rdy) r_next = R_DATA;
      end
      R_DATA: begin
        if (owner) begin
          d_ret_valid = m_ret_valid;
          d_ret_last  = m_ret_last;
          d_ret_data  = m_ret_data;
        end else begin
          i_ret_valid = m_ret_valid;
          i_ret_last  = m_ret_last;
          i_ret_data  = m_ret_data;
        end
        if (m_ret_valid && m_ret_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_cache_mem_arbiter;

  localparam int unsigned WD  = 128;
  localparam int unsigned LOB = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_rd_req, d_rd_req, d_wr_req;
  logic [2:0]    i_rd_type, d_rd_type, d_wr_type;
  logic [31:0]   i_rd_addr, d_rd_addr, d_wr_addr;
  logic [3:0]    d_wr_wstrb;
  logic [WD-1:0] d_wr_data;
  logic          i_rd_rdy, d_rd_rdy, d_wr_rdy;
  logic          i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [31:0]   i_ret_data, d_ret_data;
  logic          m_rd_req, m_rd_rdy, m_ret_valid, m_ret_last;
  logic [2:0]    m_rd_type, m_wr_type;
  logic [31:0]   m_rd_addr, m_ret_data, m_wr_addr;
  logic          m_wr_req, m_wr_rdy, m_wr_done;
  logic [3:0]    m_wr_wstrb;
  logic [WD-1:0] m_wr_data;

  int total = 0;
  int bad   = 0;
  int glog[$];

  cache_mem_arbiter #(.WR_DATA_W(WD), .LINE_OFF_BITS(LOB)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
    .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy),
    .m_wr_done(m_wr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: one outstanding read transaction and one outstanding write transaction
  logic          md_ra, md_ri, md_ro, md_last_d;
  logic [31:0]   md_raddr;
  logic [2:0]    md_rtype;
  logic          md_wa, md_wi;
  logic [31:0]   md_waddr;
  logic [2:0]    md_wtype;
  logic [3:0]    md_wstrb;
  logic [WD-1:0] md_wdata;

  always @(negedge clk) begin
    logic        wr_now, blk, ie, de, gi, gd, ret_on;
    logic [31:0] bline;
    if (!resetn) begin
      md_ra = 0; md_ri = 0; md_ro = 0; md_last_d = 1;
      md_wa = 0; md_wi = 0;
      chk("rst_i_rd_rdy", i_rd_rdy, 0);
      chk("rst_d_rd_rdy", d_rd_rdy, 0);
      chk("rst_d_wr_rdy", d_wr_rdy, 0);
      chk("rst_i_ret_valid", i_ret_valid, 0);
      chk("rst_d_ret_valid", d_ret_valid, 0);
      chk("rst_m_rd_req", m_rd_req, 0);
      chk("rst_m_wr_req", m_wr_req, 0);
      chk("rst_m_rd_addr", m_rd_addr, 0);
      chk("rst_m_wr_addr", m_wr_addr, 0);
    end else begin
      wr_now = !md_wa && d_wr_req;
      blk    = md_wa || wr_now;
      bline  = (md_wa ? md_waddr : d_wr_addr) >> LOB;
      ie     = i_rd_req && !(blk && ((i_rd_addr >> LOB) == bline));
      de     = d_rd_req && !(blk && ((d_rd_addr >> LOB) == bline));
      gi     = !md_ra && ie && (!de || md_last_d);
      gd     = !md_ra && de && !gi;
      ret_on = md_ra && md_ri && m_ret_valid;

      chk("i_rd_rdy", i_rd_rdy, gi);
      chk("d_rd_rdy", d_rd_rdy, gd);
      chk("d_wr_rdy", d_wr_rdy, !md_wa);
      chk("m_rd_req", m_rd_req, md_ra && !md_ri);
      if (md_ra && !md_ri) begin
        chk("m_rd_addr", m_rd_addr, md_raddr);
        chk("m_rd_type", m_rd_type, md_rtype);
      end
      chk("m_wr_req", m_wr_req, md_wa && !md_wi);
      if (md_wa && !md_wi) begin
        chk("m_wr_addr", m_wr_addr, md_waddr);
        chk("m_wr_type", m_wr_type, md_wtype);
        chk("m_wr_wstrb", m_wr_wstrb, md_wstrb);
        chk("m_wr_data", m_wr_data, md_wdata);
      end
      chk("i_ret_valid", i_ret_valid, ret_on && !md_ro);
      chk("d_ret_valid", d_ret_valid, ret_on && md_ro);
      if (ret_on && !md_ro) begin
        chk("i_ret_last", i_ret_last, m_ret_last);
        chk("i_ret_data", i_ret_data, m_ret_data);
      end
      if (ret_on && md_ro) begin
        chk("d_ret_last", d_ret_last, m_ret_last);
        chk("d_ret_data", d_ret_data, m_ret_data);
      end
      if (i_rd_rdy) glog.push_back(0);
      if (d_rd_rdy) glog.push_back(1);

      if (ret_on && m_ret_last) md_ra = 0;
      else if (md_ra && !md_ri && m_rd_rdy) md_ri = 1;
      if (gi || gd) begin
        md_ra = 1; md_ri = 0; md_ro = gd; md_last_d = gd;
        md_raddr = gd ? d_rd_addr : i_rd_addr;
        md_rtype = gd ? d_rd_type : i_rd_type;
      end
      if (wr_now) begin
        md_wa = 1; md_wi = 0;
        md_waddr = d_wr_addr; md_wtype = d_wr_type;
        md_wstrb = d_wr_wstrb; md_wdata = d_wr_data;
      end else if (md_wa && !md_wi && m_wr_rdy) md_wi = 1;
      else if (md_wa && md_wi && m_wr_done) md_wa = 0;
    end
  end

  // Memory side of one read: wait for the request, optionally stall, then return beats
  task automatic mem_read(input int beats, input int stall, input logic [31:0] base);
    int n = 0;
    while (!m_rd_req && n < 20) begin step(); n++; end
    if (!m_rd_req) begin
      chk("mem_read_timeout", m_rd_req, 1);
      return;
    end
    repeat (stall) step();
    m_rd_rdy = 1; step(); m_rd_rdy = 0;
    for (int k = 0; k < beats; k++) begin
      m_ret_valid = 1; m_ret_data = base + 32'(k); m_ret_last = (k == beats - 1);
      step();
    end
    m_ret_valid = 0; m_ret_last = 0;
  endtask

  task automatic do_reset();
    resetn = 0; step(); step(); resetn = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_g[4] = '{0, 1, 0, 1};
    resetn = 0;
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    i_rd_type = 0; d_rd_type = 0; d_wr_type = 0;
    i_rd_addr = 0; d_rd_addr = 0; d_wr_addr = 0;
    d_wr_wstrb = 0; d_wr_data = 0;
    m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0;
    m_wr_rdy = 0; m_wr_done = 0;
    step(); step();
    chk("reset_d_wr_rdy", d_wr_rdy, 0);
    chk("reset_m_rd_req", m_rd_req, 0);
    resetn = 1;
    step();

    // icache-only line fill
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C000040;
    #2 chk("t1_i_rd_rdy", i_rd_rdy, 1);
    step(); i_rd_req = 0;
    #2 chk("t1_m_rd_req", m_rd_req, 1);
    chk("t1_m_rd_addr", m_rd_addr, 32'h1C000040);
    m_rd_rdy = 1; step(); m_rd_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      m_ret_valid = 1; m_ret_data = 32'hA + 32'(k); m_ret_last = (k == 3);
      #2 chk("t1_i_ret_valid", i_ret_valid, 1);
      chk("t1_i_ret_data", i_ret_data, 32'hA + 32'(k));
      chk("t1_i_ret_last", i_ret_last, k == 3);
      chk("t1_d_ret_valid", d_ret_valid, 0);
      step();
    end
    m_ret_valid = 0; m_ret_last = 0;
    step();

    // Both ports held: alternation after reset, icache first
    do_reset();
    glog.delete();
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h00003000;
    d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h00007000;
    for (int g = 0; g < 4; g++) mem_read(2, 0, 32'h20 + 32'(g * 16));
    i_rd_req = 0; d_rd_req = 0;
    step();
    chk("t2_ngrants", glog.size(), 4);
    if (glog.size() >= 4)
      for (int k = 0; k < 4; k++) chk("t2_grant_order", glog[k], exp_g[k]);

    // Write line 0x1230 blocks dcache read of 0x123C; icache read of 0x2000 proceeds
    d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h00001230;
    d_wr_wstrb = 4'hF; d_wr_data = 128'h0123456789ABCDEF_FEDCBA9876543210;
    #2 chk("t3_d_wr_rdy", d_wr_rdy, 1);
    step(); d_wr_req = 0;
    d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h0000123C;
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h00002000;
    #2 chk("t3_d_rd_blocked", d_rd_rdy, 0);
    chk("t3_i_rd_rdy", i_rd_rdy, 1);
    chk("t3_m_wr_addr", m_wr_addr, 32'h00001230);
    chk("t3_m_wr_data", m_wr_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
    step(); i_rd_req = 0;
    m_wr_rdy = 1; m_rd_rdy = 1; step(); m_wr_rdy = 0; m_rd_rdy = 0;
    m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'h55;
    #2 chk("t3_i_ret_valid", i_ret_valid, 1);
    step(); m_ret_valid = 0; m_ret_last = 0;
    for (int k = 0; k < 3; k++) begin
      #2 chk("t3_d_rd_wait", d_rd_rdy, 0);
      step();
    end
    m_wr_done = 1;
    #2 chk("t3_d_rd_done_cyc", d_rd_rdy, 0);
    step(); m_wr_done = 0;
    #2 chk("t3_d_rd_after", d_rd_rdy, 1);
    step(); d_rd_req = 0;
    mem_read(1, 0, 32'h60);
    step();

    // Same-cycle write + same-line read + other-line read
    d_wr_req = 1; d_wr_addr = 32'h00004000; d_wr_wstrb = 4'h3; d_wr_data = 128'hCAFE;
    d_rd_req = 1; d_rd_addr = 32'h00004008;
    i_rd_req = 1; i_rd_addr = 32'h00005000;
    #2 chk("t4_d_wr_rdy", d_wr_rdy, 1);
    chk("t4_d_rd_rdy", d_rd_rdy, 0);
    chk("t4_i_rd_rdy", i_rd_rdy, 1);
    step(); d_wr_req = 0; i_rd_req = 0;
    m_wr_rdy = 1; step(); m_wr_rdy = 0;
    mem_read(2, 0, 32'h100);
    m_wr_done = 1; step(); m_wr_done = 0;
    #2 chk("t4_d_rd_released", d_rd_rdy, 1);
    step(); d_rd_req = 0;
    mem_read(1, 0, 32'h200);
    step();

    // Memory read stall, then reset during data phase
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1C000080;
    #2 chk("t5_i_rd_rdy", i_rd_rdy, 1);
    step(); i_rd_req = 0;
    for (int k = 0; k < 5; k++) begin
      #2 chk("t5_stall_req", m_rd_req, 1);
      chk("t5_stall_addr", m_rd_addr, 32'h1C000080);
      step();
    end
    m_rd_rdy = 1; step(); m_rd_rdy = 0;
    m_ret_valid = 1; m_ret_last = 0; m_ret_data = 32'h77;
    #2 chk("t5_beat0", i_ret_valid, 1);
    step();
    resetn = 0;
    #1 chk("t5_rst_i_ret_valid", i_ret_valid, 0);
    chk("t5_rst_m_rd_addr", m_rd_addr, 0);
    chk("t5_rst_d_wr_rdy", d_wr_rdy, 0);
    m_ret_valid = 0;
    i_rd_req = 1; i_rd_addr = 32'h00000400;
    step();
    resetn = 1;
    #2 chk("t5_idle_after_release", i_rd_rdy, 1);
    step(); i_rd_req = 0;
    mem_read(1, 0, 32'h300);
    step();

    // Uncached single-beat read; new request during the last beat waits one cycle
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h90000004;
    #2 chk("t6_d_rd_rdy", d_rd_rdy, 1);
    step(); d_rd_req = 0;
    #2 chk("t6_m_rd_type", m_rd_type, 3'b010);
    m_rd_rdy = 1; step(); m_rd_rdy = 0;
    m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'hDEAD;
    i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h00000100;
    #2 chk("t6_d_ret_valid", d_ret_valid, 1);
    chk("t6_d_ret_last", d_ret_last, 1);
    chk("t6_no_grant_last_beat", i_rd_rdy, 0);
    step(); m_ret_valid = 0; m_ret_last = 0;
    #2 chk("t6_grant_next", i_rd_rdy, 1);
    step(); i_rd_req = 0;
    mem_read(1, 0, 32'h400);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
